// File: rtl/param_memory.sv
// rtl/param_memory.sv - word memory with sequential full-array clear and 1-cycle read responses
// Optional PARAM_MEMORY_PARITY_EN adds one stored even-parity bit per word.
module param_memory #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              clr_req,
  input  logic              inj_perr,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_perr,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;
`ifdef PARAM_MEMORY_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic              req_ready_q, req_ready_d;
  logic              busy_q, busy_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_perr_q, rsp_perr_d;

  logic [MEM_W-1:0]  mem_q [DEPTH];
  logic [MEM_W-1:0]  mem_d;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [MEM_W-1:0]  rd_word;
  logic [MEM_W-1:0]  wr_word;
  logic              rd_perr;

`ifdef PARAM_MEMORY_PARITY_EN
  // Stored bit makes the word even; inj_perr flips it to plant a detectable error.
  assign wr_word = {(^req_wdata) ^ inj_perr, req_wdata};
  assign rd_perr = rd_word[DATA_W] != (^rd_word[DATA_W-1:0]);
`else
  logic unused_inj;
  assign unused_inj = inj_perr;
  assign wr_word    = req_wdata;
  assign rd_perr    = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_perr_d  = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = clr_addr_q;
    mem_d       = '0;
    rd_word     = mem_q[req_addr];
    case (state_q)
      ST_CLEAR: begin
        mem_we     = 1'b1;
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == '1) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        if (clr_req) begin
          state_d    = ST_CLEAR;
          clr_addr_d = '0;
        end else if (req_valid) begin
          if (req_write) begin
            mem_we    = 1'b1;
            mem_waddr = req_addr;
            mem_d     = wr_word;
          end else begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = rd_word[DATA_W-1:0];
            rsp_perr_d  = rd_perr;
          end
        end
      end
    endcase
    req_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d == ST_CLEAR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_CLEAR;
      clr_addr_q  <= '0;
      req_ready_q <= 1'b0;
      busy_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_perr_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_perr_q  <= rsp_perr_d;
    end
  end

  // Array is initialised by the clear sweep that always follows reset, so it carries no reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_d;
    end
  end

  assign req_ready = req_ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_perr  = rsp_perr_q;

endmodule

// File: tb/tb_param_memory.sv
// tb/tb_param_memory.sv - directed bench for param_memory with a behavioural reference model
// Honours PARAM_MEMORY_PARITY_EN when defined for the build.
module tb_param_memory;

  localparam int DEPTH = 32;
`ifdef PARAM_MEMORY_PARITY_EN
  localparam logic PAR = 1'b1;
`else
  localparam logic PAR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_write = 1'b0;
  logic [4:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       clr_req = 1'b0;
  logic       inj_perr = 1'b0;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_perr;
  logic       busy;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  int n;

  param_memory #(.DATA_W(8), .ADDR_W(5)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .clr_req(clr_req), .inj_perr(inj_perr),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_perr(rsp_perr),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference: clearing lasts DEPTH cycles; contents are all-zero once it starts.
  logic [7:0] m_mem [DEPTH];
  logic       m_bad [DEPTH];
  int         m_clear_left = DEPTH;
  logic       m_rv = 1'b0;
  logic [7:0] m_rd = 8'h00;
  logic       m_pe = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_clear_left = DEPTH;
      m_rv = 1'b0;
      m_rd = 8'h00;
      m_pe = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin m_mem[i] = 8'h00; m_bad[i] = 1'b0; end
    end else begin
      m_rv = 1'b0;
      m_pe = 1'b0;
      if (m_clear_left > 0) begin
        m_clear_left--;
      end else if (clr_req) begin
        m_clear_left = DEPTH;
        for (int i = 0; i < DEPTH; i++) begin m_mem[i] = 8'h00; m_bad[i] = 1'b0; end
      end else if (req_valid) begin
        if (req_write) begin
          m_mem[req_addr] = req_wdata;
          m_bad[req_addr] = PAR & inj_perr;
        end else begin
          m_rv = 1'b1;
          m_rd = m_mem[req_addr];
          m_pe = m_bad[req_addr];
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("req_ready", 64'(req_ready), 64'(m_clear_left == 0));
      chk("busy", 64'(busy), 64'(m_clear_left != 0));
      chk("rsp_valid", 64'(rsp_valid), 64'(m_rv));
      chk("rsp_rdata", 64'(rsp_rdata), 64'(m_rd));
      chk("rsp_perr", 64'(rsp_perr), 64'(m_pe));
    end
  end

  task automatic req(input logic w, input int a, input logic [7:0] d, input logic inj);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a[4:0];
    req_wdata = d;
    inj_perr  = inj;
    @(posedge clk); #1;
    req_valid = 1'b0;
    inj_perr  = 1'b0;
  endtask

  task automatic wait_ready(output int cnt);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_ready) break;
      cnt++;
    end
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 64'(req_ready), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    chk({tag, "_rv"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_rd"}, 64'(rsp_rdata), 64'h00);
    chk({tag, "_pe"}, 64'(rsp_perr), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    #1 reset = 1'b1;
    mon_en = 1'b1;
    #1 chk_reset_outputs("por");
    @(posedge clk); @(posedge clk); #1 reset = 1'b0;
    wait_ready(n);
    chk("init_clear_cycles", 64'(n), 64'd32);

    req(1'b0, 31, 8'h00, 1'b0);
    chk("rd31_valid", 64'(rsp_valid), 64'd1);
    chk("rd31_data", 64'(rsp_rdata), 64'h00);

    req(1'b1, 3, 8'hA5, 1'b0);
    chk("wr_no_rsp", 64'(rsp_valid), 64'd0);
    req(1'b0, 3, 8'h00, 1'b0);
    chk("raw_a5", 64'(rsp_rdata), 64'hA5);

    req(1'b1, 0, 8'h11, 1'b0);
    req(1'b1, 1, 8'h22, 1'b0);
    req(1'b1, 2, 8'h33, 1'b0);
    req(1'b0, 0, 8'h00, 1'b0); chk("b2b_0", 64'({rsp_valid, rsp_rdata}), 64'h111);
    req(1'b0, 1, 8'h00, 1'b0); chk("b2b_1", 64'({rsp_valid, rsp_rdata}), 64'h122);
    req(1'b0, 2, 8'h00, 1'b0); chk("b2b_2", 64'({rsp_valid, rsp_rdata}), 64'h133);
    @(posedge clk); #1;
    chk("hold_rdata", 64'({rsp_valid, rsp_rdata}), 64'h033);

    clr_req = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_addr = 5'd3;
    @(posedge clk); #1;
    clr_req = 1'b0; req_valid = 1'b0;
    chk("clr_beats_read", 64'(rsp_valid), 64'd0);
    chk("clr_busy", 64'(busy), 64'd1);
    wait_ready(n);
    chk("clr_cycles", 64'(n), 64'd32);
    req(1'b0, 3, 8'h00, 1'b0);
    chk("clr_rd3", 64'({rsp_valid, rsp_rdata}), 64'h100);

    req(1'b1, 9, 8'h5A, 1'b0);
    req(1'b0, 9, 8'h00, 1'b0);
    chk("rd9", 64'(rsp_rdata), 64'h5A);
    reset = 1'b1;
    #1 chk_reset_outputs("rst_inflight");
    @(posedge clk); #1 reset = 1'b0;
    wait_ready(n);
    chk("rst_inflight_cycles", 64'(n), 64'd32);

    req(1'b1, 4, 8'hC3, 1'b0);
    clr_req = 1'b1;
    @(posedge clk); #1 clr_req = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    #1 chk_reset_outputs("rst_addr10");
    @(posedge clk); #1 reset = 1'b0;
    wait_ready(n);
    chk("rst_addr10_cycles", 64'(n), 64'd32);
    req(1'b0, 4, 8'h00, 1'b0);
    chk("rd4_cleared", 64'({rsp_valid, rsp_rdata}), 64'h100);

    req(1'b1, 7, 8'h0F, 1'b1);
    req(1'b0, 7, 8'h00, 1'b0);
    chk("perr_inj", 64'(rsp_perr), 64'(PAR));
    chk("perr_inj_data", 64'(rsp_rdata), 64'h0F);
    req(1'b1, 7, 8'h0F, 1'b0);
    req(1'b0, 7, 8'h00, 1'b0);
    chk("perr_clean", 64'(rsp_perr), 64'd0);

    for (int i = 0; i < DEPTH; i++) req(1'b1, i, 8'(i * 37) ^ 8'h5C, 1'b0);
    for (int i = DEPTH - 1; i >= 0; i--) req(1'b0, i, 8'h00, 1'b0);
    chk("sweep_last", 64'(rsp_rdata), 64'h5C);

    @(posedge clk); #1;
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_memory.md
PARAM_MEMORY -- requirements
Module: param_memory

Interface
REQ-001 SHALL provide parameter DATA_W, default 8, word width in bits (1..64).
REQ-002 SHALL provide parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W words (default 32).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  request accepted this cycle when high with req_valid.
REQ-007 SHALL have port req_write  input  1  1 = write, 0 = read.
REQ-008 SHALL have port req_addr  input  ADDR_W  word address.
REQ-009 SHALL have port req_wdata  input  DATA_W  write data.
REQ-010 SHALL have port clr_req  input  1  start full-array clear.
REQ-011 SHALL have port inj_perr  input  1  store bad parity on accepted write (parity build only).
REQ-012 SHALL have port rsp_valid  output  1  one-cycle read-response pulse.
REQ-013 SHALL have port rsp_rdata  output  DATA_W  read data.
REQ-014 SHALL have port rsp_perr  output  1  parity error on current response.
REQ-015 SHALL have port busy  output  1  clear sequence in progress.

Function
REQ-016 FSM states SHALL be CLEAR and IDLE only.
REQ-017 CLEAR SHALL write zero to one address per cycle, 0 up to DEPTH-1 ascending, then enter IDLE: exactly DEPTH cycles.
REQ-018 In CLEAR: busy=1, req_ready=0; requests and clr_req ignored.
REQ-019 In IDLE: busy=0, req_ready=1; clr_req=1 enters CLEAR next cycle, taking priority over a same-cycle req_valid (request not accepted).
REQ-020 Accepted write SHALL update mem[req_addr] at that edge; no response generated.
REQ-021 Accepted read SHALL assert rsp_valid for exactly one cycle on the following cycle with rsp_rdata = mem[req_addr]; read latency 1.
REQ-022 Back-to-back reads every cycle SHALL give one response per cycle, in order.
REQ-023 Read one cycle after a write to the same address SHALL return the new data.
REQ-024 rsp_rdata SHALL hold its last value while rsp_valid=0.
REQ-025 Address wrap: none possible; every req_addr value is a valid word.
REQ-026 Memory contents SHALL be undefined-free: only reset/clear, and writes, modify them.

Reset
REQ-027 reset=1 SHALL immediately force state CLEAR with clear address 0, req_ready=0, busy=1, rsp_valid=0, rsp_rdata=0, rsp_perr=0.
REQ-028 On reset release, a full CLEAR of DEPTH cycles SHALL run before first req_ready=1.
REQ-029 Reset during CLEAR or IDLE SHALL restart clearing from address 0; in-flight read response discarded.

Configuration
REQ-030 Macro PARAM_MEMORY_PARITY_EN SHALL, when defined, widen storage to DATA_W+1 bits holding even parity of the data.
REQ-031 With macro: write stores computed parity, inverted when inj_perr=1; CLEAR stores valid parity (0); rsp_perr = parity mismatch on read, valid with rsp_valid, else 0.
REQ-032 Without macro: storage DATA_W bits, inj_perr ignored, rsp_perr tied 0.

Verification
REQ-033 Reset pulse, release -> busy=1 and req_ready=0 for 32 cycles, then req_ready=1; read addr 31 -> rsp_valid next cycle, rsp_rdata=8'h00.
REQ-034 Write 8'hA5 to addr 3, read addr 3 next cycle -> rsp_rdata=8'hA5 one cycle after read accept.
REQ-035 Reads addr 0,1,2 on three consecutive cycles after writes 8'h11,8'h22,8'h33 -> three consecutive rsp_valid pulses with 11,22,33.
REQ-036 clr_req and read of addr 3 (holding 8'hA5) in same cycle -> read not accepted, 32 busy cycles, then read addr 3 returns 8'h00.
REQ-037 Reset asserted at clear address 10 -> outputs to reset values at once, full 32-cycle clear after release.
REQ-038 With PARAM_MEMORY_PARITY_EN: write 8'h0F with inj_perr=1 to addr 7, read -> rsp_perr=1; rewrite with inj_perr=0, read -> rsp_perr=0; without macro rsp_perr=0 always.
